// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: operation codes, FSM states and
// default datapath widths.
package ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_ADDI = 3'b101,
        OP_LDST = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/ex_fwd_mux.sv
// Forwarding select for one source operand; EX/MEM beats MEM/WB and
// register 0 is never forwarded.
module ex_fwd_mux #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic [RAW-1:0]  rs,
    input  logic [XLEN-1:0] id_data,
    input  logic [RAW-1:0]  exmem_rsd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            exmem_we,
    input  logic [RAW-1:0]  memwb_rsd,
    input  logic [XLEN-1:0] memwb_data,
    input  logic            memwb_we,
    output logic [XLEN-1:0] data
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs != {RAW{1'b0}});

    // Priority select: youngest producer first
    always_comb begin
        data = id_data;
        if (exmem_we && rs_nonzero_s && (exmem_rsd == rs)) begin
            data = exmem_data;
        end else if (memwb_we && rs_nonzero_s && (memwb_rsd == rs)) begin
            data = memwb_data;
        end else begin
            data = id_data;
        end
    end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: forwarded single-cycle ALU plus an iterative shift-add
// multiplier that stalls upstream while it runs.
module ex_stage_unit
    import ex_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int RAW       = RAW_DEF,
    parameter int MUL_STEPS = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [RAW-1:0]  rs1_i,
    input  logic [RAW-1:0]  rs2_i,
    input  logic [RAW-1:0]  rsd_i,
    input  logic [2:0]      Op_i,
    input  logic            valid_i,
    input  logic [RAW-1:0]  exmem_rsd_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic            exmem_we_i,
    input  logic [RAW-1:0]  memwb_rsd_i,
    input  logic [XLEN-1:0] memwb_data_i,
    input  logic            memwb_we_i,
    output logic [XLEN-1:0] result_o,
    output logic [RAW-1:0]  rsd_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [2:0]      Op_o,
    output logic            valid_o,
    output logic            stall_o
);

    localparam int              CNT_W    = $clog2(MUL_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_STEPS - 1);

    op_e              op_s;
    logic [XLEN-1:0]  fwd_a_s;
    logic [XLEN-1:0]  fwd_b_s;
    logic [XLEN-1:0]  op_b_s;
    logic [XLEN-1:0]  alu_res_s;
    logic [XLEN-1:0]  acc_next_s;
    logic             stall_s;

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]  mplier_r;
    logic [XLEN-1:0]  acc_r;
    logic [RAW-1:0]   mul_rsd_r;
    logic [2:0]       mul_op_r;

    assign op_s = op_e'(Op_i);

    ex_fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_a (
        .rs         (rs1_i),
        .id_data    (rs1_data_i),
        .exmem_rsd  (exmem_rsd_i),
        .exmem_data (exmem_data_i),
        .exmem_we   (exmem_we_i),
        .memwb_rsd  (memwb_rsd_i),
        .memwb_data (memwb_data_i),
        .memwb_we   (memwb_we_i),
        .data       (fwd_a_s)
    );

    ex_fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_b (
        .rs         (rs2_i),
        .id_data    (rs2_data_i),
        .exmem_rsd  (exmem_rsd_i),
        .exmem_data (exmem_data_i),
        .exmem_we   (exmem_we_i),
        .memwb_rsd  (memwb_rsd_i),
        .memwb_data (memwb_data_i),
        .memwb_we   (memwb_we_i),
        .data       (fwd_b_s)
    );

    // Single-cycle ALU; immediate forms take operand B from imm_i
    always_comb begin
        if (op_s == OP_ADDI || op_s == OP_LDST) begin
            op_b_s = imm_i;
        end else begin
            op_b_s = fwd_b_s;
        end
        case (op_s)
            OP_AND:                   alu_res_s = fwd_a_s & op_b_s;
            OP_OR:                    alu_res_s = fwd_a_s | op_b_s;
            OP_ADD, OP_ADDI, OP_LDST: alu_res_s = fwd_a_s + op_b_s;
            OP_SUB:                   alu_res_s = fwd_a_s - op_b_s;
            default:                  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // One shift-add step of the multiplier
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Stall drops on the last busy step so upstream advances at that edge
    always_comb begin
        stall_s = 1'b0;
        if (!rst_i) begin
            stall_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            stall_s = valid_i && (op_s == OP_MUL);
        end else begin
            stall_s = (cnt_r != LAST_CNT);
        end
    end

    assign stall_o = stall_s;

    // Control FSM, multiplier datapath and registered EX/MEM outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            mcand_r      <= {XLEN{1'b0}};
            mplier_r     <= {XLEN{1'b0}};
            acc_r        <= {XLEN{1'b0}};
            mul_rsd_r    <= {RAW{1'b0}};
            mul_op_r     <= OP_NOP;
            result_o     <= {XLEN{1'b0}};
            rsd_o        <= {RAW{1'b0}};
            store_data_o <= {XLEN{1'b0}};
            Op_o         <= OP_NOP;
            valid_o      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && op_s == OP_MUL) begin
                        mcand_r   <= fwd_a_s;
                        mplier_r  <= fwd_b_s;
                        acc_r     <= {XLEN{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        mul_rsd_r <= rsd_i;
                        mul_op_r  <= Op_i;
                        valid_o   <= 1'b0;
                        state_r   <= ST_MUL_BUSY;
                    end else if (valid_i && op_s != OP_NOP) begin
                        result_o     <= alu_res_s;
                        rsd_o        <= rsd_i;
                        Op_o         <= Op_i;
                        store_data_o <= fwd_b_s;
                        valid_o      <= 1'b1;
                    end else begin
                        valid_o <= 1'b0;
                    end
                end
                ST_MUL_BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                    if (cnt_r == LAST_CNT) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        result_o <= acc_next_s;
                        rsd_o    <= mul_rsd_r;
                        Op_o     <= mul_op_r;
                        valid_o  <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed self-checking bench for ex_stage_unit: ALU ops, forwarding,
// iterative multiply timing, back-to-back multiplies and reset behaviour.
module tb_ex_stage_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_i, rs2_i, rsd_i;
    logic [2:0]  Op_i;
    logic        valid_i;
    logic [4:0]  exmem_rsd_i, memwb_rsd_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic        exmem_we_i, memwb_we_i;
    logic [31:0] result_o, store_data_o;
    logic [4:0]  rsd_o;
    logic [2:0]  Op_o;
    logic        valid_o, stall_o;

    int total = 0;
    int bad   = 0;

    ex_stage_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rsd_i(rsd_i), .Op_i(Op_i), .valid_i(valid_i),
        .exmem_rsd_i(exmem_rsd_i), .exmem_data_i(exmem_data_i), .exmem_we_i(exmem_we_i),
        .memwb_rsd_i(memwb_rsd_i), .memwb_data_i(memwb_data_i), .memwb_we_i(memwb_we_i),
        .result_o(result_o), .rsd_o(rsd_o), .store_data_o(store_data_o), .Op_o(Op_o),
        .valid_o(valid_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic no_fwd();
        exmem_we_i = 1'b0; memwb_we_i = 1'b0;
        exmem_rsd_i = 5'd0; memwb_rsd_i = 5'd0;
        exmem_data_i = 32'd0; memwb_data_i = 32'd0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd);
        Op_i = op; rs1_data_i = a; rs2_data_i = b; imm_i = imm;
        rs1_i = r1; rs2_i = r2; rsd_i = rd; valid_i = 1'b1;
    endtask

    // Runs an already-presented MUL until valid_o rises (or a 40-edge bound)
    task automatic mul_wait(output int edges, output int stalls);
        edges = 0; stalls = 0;
        while (edges < 40) begin
            if (stall_o) stalls++;
            step();
            edges++;
            if (edges == 3) begin
                rs1_data_i = 32'h1234_5678;
                rs2_data_i = 32'h0000_0011;
            end
            if (valid_o) break;
        end
    endtask

    task automatic test_reset();
        no_fwd();
        drive(3'b100, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd7);
        rst_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall_during: got %b want 0", stall_o); end
        step(); step();
        total++;
        if ({result_o, rsd_o, store_data_o, Op_o, valid_o, stall_o} !== {32'd0, 5'd0, 32'd0, 3'b111, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got res=%h rsd=%0d sd=%h op=%b v=%b st=%b want 0/0/0/111/0/0",
                     result_o, rsd_o, store_data_o, Op_o, valid_o, stall_o);
        end
        valid_i = 1'b0;
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_alu();
        no_fwd();
        drive(3'b010, 32'd7, 32'd5, 32'd0, 5'd1, 5'd2, 5'd3);
        step();
        total++;
        if ({result_o, rsd_o, Op_o, valid_o, store_data_o} !== {32'd12, 5'd3, 3'b010, 1'b1, 32'd5}) begin
            bad++;
            $display("FAIL add: got res=%0d rsd=%0d op=%b v=%b sd=%0d want 12/3/010/1/5",
                     result_o, rsd_o, Op_o, valid_o, store_data_o);
        end
        drive(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd1, 5'd2, 5'd4);
        step();
        total++;
        if (result_o !== 32'h0000_F000) begin bad++; $display("FAIL and: got %h want 0000f000", result_o); end
        drive(3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 32'd0, 5'd1, 5'd2, 5'd4);
        step();
        total++;
        if (result_o !== 32'h0000_FFFF) begin bad++; $display("FAIL or: got %h want 0000ffff", result_o); end
        drive(3'b011, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4);
        step();
        total++;
        if (result_o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_wrap: got %h want fffffffe", result_o); end
        drive(3'b101, 32'd10, 32'd99, 32'hFFFF_FFFD, 5'd1, 5'd2, 5'd4);
        step();
        total++;
        if (result_o !== 32'd7) begin bad++; $display("FAIL addi: got %0d want 7", result_o); end
        drive(3'b110, 32'h100, 32'hAB, 32'h20, 5'd1, 5'd2, 5'd6);
        step();
        total++;
        if ({result_o, store_data_o, Op_o, rsd_o} !== {32'h120, 32'hAB, 3'b110, 5'd6}) begin
            bad++;
            $display("FAIL ldst: got addr=%h sd=%h op=%b rsd=%0d want 120/ab/110/6",
                     result_o, store_data_o, Op_o, rsd_o);
        end
    endtask

    task automatic test_bubble();
        drive(3'b010, 32'd1, 32'd1, 32'd0, 5'd1, 5'd2, 5'd9);
        valid_i = 1'b0;
        step();
        total++;
        if ({valid_o, result_o, rsd_o} !== {1'b0, 32'h120, 5'd6}) begin
            bad++;
            $display("FAIL bubble_hold: got v=%b res=%h rsd=%0d want 0/120/6", valid_o, result_o, rsd_o);
        end
        drive(3'b111, 32'd1, 32'd1, 32'd0, 5'd1, 5'd2, 5'd9);
        step();
        total++;
        if ({valid_o, result_o, stall_o} !== {1'b0, 32'h120, 1'b0}) begin
            bad++;
            $display("FAIL nop_hold: got v=%b res=%h st=%b want 0/120/0", valid_o, result_o, stall_o);
        end
    endtask

    task automatic test_forward();
        exmem_rsd_i = 5'd4; exmem_data_i = 32'd30; exmem_we_i = 1'b1;
        memwb_rsd_i = 5'd4; memwb_data_i = 32'd50; memwb_we_i = 1'b1;
        drive(3'b011, 32'd100, 32'd100, 32'd0, 5'd4, 5'd4, 5'd8);
        step();
        total++;
        if ({result_o, store_data_o} !== {32'd0, 32'd30}) begin bad++; $display("FAIL fwd_sub_exmem: got %0d sd=%0d want 0/30", result_o, store_data_o); end
        drive(3'b010, 32'd100, 32'd100, 32'd0, 5'd4, 5'd4, 5'd8);
        step();
        total++;
        if (result_o !== 32'd60) begin bad++; $display("FAIL fwd_add_exmem_wins: got %0d want 60", result_o); end
        exmem_we_i = 1'b0;
        step();
        total++;
        if ({result_o, store_data_o} !== {32'd100, 32'd50}) begin bad++; $display("FAIL fwd_memwb: got %0d sd=%0d want 100/50", result_o, store_data_o); end
        exmem_we_i = 1'b1;
        exmem_rsd_i = 5'd0; memwb_rsd_i = 5'd0;
        drive(3'b010, 32'd100, 32'd100, 32'd0, 5'd0, 5'd0, 5'd8);
        step();
        total++;
        if (result_o !== 32'd200) begin bad++; $display("FAIL fwd_reg0: got %0d want 200", result_o); end
        exmem_rsd_i = 5'd4; memwb_rsd_i = 5'd6;
        drive(3'b010, 32'd100, 32'd100, 32'd0, 5'd4, 5'd6, 5'd8);
        step();
        total++;
        if ({result_o, store_data_o} !== {32'd80, 32'd50}) begin bad++; $display("FAIL fwd_split: got %0d sd=%0d want 80/50", result_o, store_data_o); end
        no_fwd();
    endtask

    task automatic test_mul();
        int edges, stalls;
        no_fwd();
        drive(3'b100, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd1, 5'd2, 5'd9);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL mul_accept_stall: got %b want 1", stall_o); end
        mul_wait(edges, stalls);
        total++;
        if (edges !== 33 || stalls !== 32) begin
            bad++;
            $display("FAIL mul_timing: got edges=%0d stalls=%0d want 33/32", edges, stalls);
        end
        total++;
        if ({result_o, rsd_o, Op_o, valid_o} !== {32'hFFFF_FFFD, 5'd9, 3'b100, 1'b1}) begin
            bad++;
            $display("FAIL mul_result: got res=%h rsd=%0d op=%b v=%b want fffffffd/9/100/1",
                     result_o, rsd_o, Op_o, valid_o);
        end
        drive(3'b101, 32'd40, 32'd0, 32'd2, 5'd1, 5'd2, 5'd10);
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL addi_after_mul_stall: got %b want 0", stall_o); end
        step();
        total++;
        if ({result_o, rsd_o, valid_o} !== {32'd42, 5'd10, 1'b1}) begin
            bad++;
            $display("FAIL addi_after_mul: got res=%0d rsd=%0d v=%b want 42/10/1", result_o, rsd_o, valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int edges, stalls;
        drive(3'b100, 32'd6, 32'd7, 32'd0, 5'd1, 5'd2, 5'd11);
        mul_wait(edges, stalls);
        total++;
        if ({result_o, rsd_o, valid_o} !== {32'd42, 5'd11, 1'b1} || edges !== 33) begin
            bad++;
            $display("FAIL b2b_first: got res=%0d rsd=%0d v=%b edges=%0d want 42/11/1/33", result_o, rsd_o, valid_o, edges);
        end
        drive(3'b100, 32'd0, 32'd9, 32'd0, 5'd1, 5'd2, 5'd12);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_no_gap: got stall=%b want 1", stall_o); end
        mul_wait(edges, stalls);
        total++;
        if ({result_o, rsd_o, valid_o} !== {32'd0, 5'd12, 1'b1} || edges !== 33 || stalls !== 32) begin
            bad++;
            $display("FAIL b2b_second: got res=%0d rsd=%0d v=%b edges=%0d stalls=%0d want 0/12/1/33/32",
                     result_o, rsd_o, valid_o, edges, stalls);
        end
        valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        no_fwd();
        drive(3'b100, 32'd6, 32'd7, 32'd0, 5'd1, 5'd2, 5'd13);
        step();
        for (int i = 0; i < 10; i++) step();
        rst_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b want 0", stall_o); end
        step();
        rst_i = 1'b1;
        valid_i = 1'b0;
        #1;
        total++;
        if ({valid_o, stall_o, result_o, Op_o} !== {1'b0, 1'b0, 32'd0, 3'b111}) begin
            bad++;
            $display("FAIL rst_mid_state: got v=%b st=%b res=%h op=%b want 0/0/0/111", valid_o, stall_o, result_o, Op_o);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid_o || stall_o) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_result: got %0d active cycles want 0", seen); end
        drive(3'b010, 32'd20, 32'd22, 32'd0, 5'd1, 5'd2, 5'd14);
        step();
        total++;
        if ({result_o, rsd_o, valid_o} !== {32'd42, 5'd14, 1'b1}) begin
            bad++;
            $display("FAIL add_after_rst: got res=%0d rsd=%0d v=%b want 42/14/1", result_o, rsd_o, valid_o);
        end
        valid_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i = 1'b0;
        valid_i = 1'b0;
        no_fwd();
        drive(3'b111, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        valid_i = 1'b0;
        test_reset();
        test_alu();
        test_bubble();
        test_forward();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
